// File: rtl/scan_code_sequencer_if.sv
// Byte-input and event-output stream signals of scan_code_sequencer.
// master = byte producer / event consumer side, slave = sequencer side.
interface scan_code_sequencer_if;
    logic       code_strobe;
    logic [7:0] code_data;
    logic       parity_ok;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_code;
    logic       out_extended;
    logic       out_break;

    modport master (
        output code_strobe, code_data, parity_ok, out_ready,
        input  out_valid, out_code, out_extended, out_break
    );

    modport slave (
        input  code_strobe, code_data, parity_ok, out_ready,
        output out_valid, out_code, out_extended, out_break
    );
endinterface

// File: rtl/scan_code_sequencer.sv
// Folds E0/F0 prefix bytes into key events and buffers them in a show-ahead FIFO.
// Define SCAN_SEQ_TIMEOUT_EN to compile in the prefix timeout counter.
module scan_code_sequencer #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                         fclk,
    input  logic                         rst,
    scan_code_sequencer_if.slave         bus,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         parity_err,
    output logic                         seq_err,
    output logic                         overflow
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] CODE_E0 = 8'hE0;
    localparam logic [7:0] CODE_F0 = 8'hF0;

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_e;

    state_e      state_q, state_d;
    logic        parity_err_q, parity_err_d;
    logic        seq_err_q, seq_err_d;
    logic        overflow_q, overflow_d;
    logic [AW:0] level_q, level_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [9:0]  mem_q [FIFO_DEPTH];

    logic        push, push_ext, push_brk, push_ok, pop, full;
    logic        is_e0, is_f0;
    logic [9:0]  head;

    assign is_e0 = (bus.code_data == CODE_E0);
    assign is_f0 = (bus.code_data == CODE_F0);

`ifdef SCAN_SEQ_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;

    assign tmo_hit = (state_q != IDLE) && (tmo_q == TMO_LAST);
    always_comb begin
        if (bus.code_strobe || state_q == IDLE || tmo_hit) tmo_d = '0;
        else                                               tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge fclk) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`endif

    always_comb begin
        state_d      = state_q;
        push         = 1'b0;
        push_ext     = 1'b0;
        push_brk     = 1'b0;
        parity_err_d = 1'b0;
        seq_err_d    = 1'b0;
        if (bus.code_strobe) begin
            if (!bus.parity_ok) begin
                parity_err_d = 1'b1;
                state_d      = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (is_e0)      state_d = GOT_E0;
                        else if (is_f0) state_d = GOT_F0;
                        else            push    = 1'b1;
                    end
                    GOT_E0: begin
                        if (is_f0) state_d = GOT_E0F0;
                        else if (!is_e0) begin
                            push     = 1'b1;
                            push_ext = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                    GOT_F0: begin
                        state_d = IDLE;
                        if (is_e0 || is_f0) seq_err_d = 1'b1;
                        else begin
                            push     = 1'b1;
                            push_brk = 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        if (is_e0 || is_f0) seq_err_d = 1'b1;
                        else begin
                            push     = 1'b1;
                            push_ext = 1'b1;
                            push_brk = 1'b1;
                        end
                    end
                endcase
            end
        end
`ifdef SCAN_SEQ_TIMEOUT_EN
        else if (tmo_hit) begin
            seq_err_d = 1'b1;
            state_d   = IDLE;
        end
`endif
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        full       = (level_q == (AW+1)'(FIFO_DEPTH));
        pop        = bus.out_valid && bus.out_ready;
        push_ok    = push && (!full || pop);
        overflow_d = push && full && !pop;
        wr_d       = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d       = pop ? rd_q + 1'b1 : rd_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q      <= IDLE;
            parity_err_q <= 1'b0;
            seq_err_q    <= 1'b0;
            overflow_q   <= 1'b0;
            level_q      <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
        end else begin
            state_q      <= state_d;
            parity_err_q <= parity_err_d;
            seq_err_q    <= seq_err_d;
            overflow_q   <= overflow_d;
            level_q      <= level_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
        end
    end

    always_ff @(posedge fclk) begin
        if (push_ok) mem_q[wr_q] <= {push_ext, push_brk, bus.code_data};
    end

    assign head             = mem_q[rd_q];
    assign bus.out_valid    = (level_q != '0);
    assign bus.out_code     = bus.out_valid ? head[7:0] : '0;
    assign bus.out_extended = bus.out_valid && head[9];
    assign bus.out_break    = bus.out_valid && head[8];
    assign fifo_level       = level_q;
    assign parity_err       = parity_err_q;
    assign seq_err          = seq_err_q;
    assign overflow         = overflow_q;
endmodule

// File: tb/tb_scan_code_sequencer.sv
// Directed bench for scan_code_sequencer with a queue scoreboard of expected events.
module tb_scan_code_sequencer;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned TB_TMO = 64;
`ifdef SCAN_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       fclk;
    logic       rst;
    logic [3:0] fifo_level;
    logic       parity_err, seq_err, overflow;

    scan_code_sequencer_if intf ();

    scan_code_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TB_TMO)) dut (
        .fclk       (fclk),
        .rst        (rst),
        .bus        (intf),
        .fifo_level (fifo_level),
        .parity_err (parity_err),
        .seq_err    (seq_err),
        .overflow   (overflow)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q [$];
    int max_level = 0;
    int seq_cnt = 0;
    int perr_cnt = 0;
    int ovf_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Event monitor: compares each popped head entry with the scoreboard.
    always @(negedge fclk) begin
        if (!rst) begin
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            if (seq_err)    seq_cnt++;
            if (parity_err) perr_cnt++;
            if (overflow)   ovf_cnt++;
            if (intf.out_valid && intf.out_ready) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0)
                    chk("event", {22'd0, intf.out_extended, intf.out_break, intf.out_code},
                        {22'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic strobe(input logic [7:0] b, input logic p);
        intf.code_strobe = 1'b1;
        intf.code_data   = b;
        intf.parity_ok   = p;
        @(posedge fclk); #1;
        intf.code_strobe = 1'b0;
        intf.code_data   = 8'h00;
        intf.parity_ok   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge fclk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge fclk);
        #1;
        chk(tag, 32'(exp_q.size()), 32'd0);
        idle(2);
    endtask

    initial begin
        int s0;
        rst = 1'b1;
        intf.code_strobe = 1'b0;
        intf.code_data   = 8'h00;
        intf.parity_ok   = 1'b0;
        intf.out_ready   = 1'b1;
        idle(3);
        rst = 1'b0;
        chk("rst_valid", 32'(intf.out_valid), 32'd0);
        chk("rst_head", {21'd0, intf.out_extended, intf.out_break, intf.out_code}, 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_pulses", {29'd0, parity_err, seq_err, overflow}, 32'd0);

        // Plain code, break code, 1-cycle latency
        exp_q.push_back({2'b00, 8'h1C});
        strobe(8'h1C, 1'b1);
        chk("lat_valid", 32'(intf.out_valid), 32'd1);
        chk("lat_level", 32'(fifo_level), 32'd1);
        strobe(8'hF0, 1'b1);
        exp_q.push_back({2'b01, 8'h1C});
        strobe(8'h1C, 1'b1);
        drain("drain_brk");
        chk("no_err_pulses", 32'(seq_cnt + perr_cnt + ovf_cnt), 32'd0);

        // E0 F0 74
        max_level = 0;
        strobe(8'hE0, 1'b1);
        strobe(8'hF0, 1'b1);
        exp_q.push_back({2'b11, 8'h74});
        strobe(8'h74, 1'b1);
        drain("drain_e0f0");
        chk("peak_level", 32'(max_level), 32'd1);

        // F0 F0 malformed
        strobe(8'hF0, 1'b1);
        strobe(8'hF0, 1'b1);
        chk("seq_err_pulse", 32'(seq_err), 32'd1);
        idle(1);
        chk("seq_err_one_cycle", 32'(seq_err), 32'd0);
        exp_q.push_back({2'b00, 8'h1C});
        strobe(8'h1C, 1'b1);
        drain("drain_after_seq");

        // Fill, overflow, simultaneous push/pop at full
        intf.out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back({2'b00, 8'(i)});
            strobe(8'(i), 1'b1);
        end
        chk("full_level", 32'(fifo_level), 32'd8);
        chk("no_ovf_at_fill", 32'(overflow), 32'd0);
        strobe(8'h09, 1'b1);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(fifo_level), 32'd8);
        intf.out_ready = 1'b1;
        exp_q.push_back({2'b00, 8'h0A});
        strobe(8'h0A, 1'b1);
        chk("pushpop_full_ovf", 32'(overflow), 32'd0);
        chk("pushpop_full_level", 32'(fifo_level), 32'd8);
        drain("drain_fill");
        chk("ovf_count", 32'(ovf_cnt), 32'd1);

        // Prefix timeout
        s0 = seq_cnt;
        strobe(8'hE0, 1'b1);
        idle(TB_TMO - 1);
        chk("tmo_early", 32'(seq_err), 32'd0);
        idle(1);
        chk("tmo_pulse", 32'(seq_err), 32'(TMO_EN));
        idle(4);
        chk("tmo_count", 32'(seq_cnt - s0), 32'(TMO_EN));
        exp_q.push_back({~TMO_EN, 1'b0, 8'h75});
        strobe(8'h75, 1'b1);
        drain("drain_tmo");

        // Bad parity drops pending prefix
        strobe(8'hE0, 1'b1);
        strobe(8'h1C, 1'b0);
        chk("perr_pulse", 32'(parity_err), 32'd1);
        chk("perr_no_push", 32'(fifo_level), 32'd0);
        exp_q.push_back({2'b00, 8'h1C});
        strobe(8'h1C, 1'b1);
        drain("drain_perr");
        chk("perr_count", 32'(perr_cnt), 32'd1);

        // Reset mid-sequence with buffered events
        intf.out_ready = 1'b0;
        strobe(8'h21, 1'b1);
        strobe(8'h22, 1'b1);
        strobe(8'hE0, 1'b1);
        chk("pre_rst_level", 32'(fifo_level), 32'd2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_valid", 32'(intf.out_valid), 32'd0);
        intf.out_ready = 1'b1;
        exp_q.push_back({2'b00, 8'h1C});
        strobe(8'h1C, 1'b1);
        drain("drain_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
